// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter sharing one registered 4-state gate evaluator among NREQ requesters.
// Results return on a common valid/ready channel tagged with the one-hot requester ID.
module gate_eval_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_a,
  input  logic [2*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic              rsp_valid,
  output logic [NREQ-1:0]   rsp_id,
  output logic [1:0]        rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [CNTW-1:0]   eval_count,
  output logic [CNTW-1:0]   x_count
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t            state;
  logic [IDXW-1:0]   rr_ptr;
  logic [NREQ-1:0]   grant;
  logic [IDXW-1:0]   grant_idx;
  logic [1:0]        a_sel, b_sel, op_sel;
  logic              found;
  logic [1:0]        a_p0, b_p0, op_p0;
  logic [NREQ-1:0]   id_p0;
  logic [IDXW-1:0]   idx_p0;

  // Operand code 11 is X just like 10; results use 00/01/10 only.
  function automatic logic [1:0] gate_eval(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] op);
    logic       az, ao, bz, bo;
    logic [1:0] and_r, or_r, res;
    az    = (a == 2'b00);
    ao    = (a == 2'b01);
    bz    = (b == 2'b00);
    bo    = (b == 2'b01);
    and_r = (az || bz) ? 2'b00 : ((ao && bo) ? 2'b01 : 2'b10);
    or_r  = (ao || bo) ? 2'b01 : ((az && bz) ? 2'b00 : 2'b10);
    case (op)
      2'b00:   res = and_r;
      2'b01:   res = or_r;
      2'b10:   res = (a[1] || b[1]) ? 2'b10 : {1'b0, a[0] ^ b[0]};
      default: res = and_r[1] ? 2'b10 : {1'b0, ~and_r[0]};
    endcase
    return res;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Two passes give the wrap-around search: indices >= rr_ptr first, then the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    a_sel     = '0;
    b_sel     = '0;
    op_sel    = '0;
    found     = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_valid[j] && (j >= int'(rr_ptr))) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDXW'(j);
        a_sel     = req_a[2*j +: 2];
        b_sel     = req_b[2*j +: 2];
        op_sel    = req_op[2*j +: 2];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDXW'(j);
        a_sel     = req_a[2*j +: 2];
        b_sel     = req_b[2*j +: 2];
        op_sel    = req_op[2*j +: 2];
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  // Stage p0: operands captured on the accept handshake
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      a_p0  <= a_sel;
      b_p0  <= b_sel;
      op_p0 <= op_sel;
      id_p0 <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      idx_p0     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= 2'b00;
      eval_count <= '0;
      x_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx_p0 <= grant_idx;
            state  <= EVAL;
          end
        end
        // Stage p1: evaluate and present the response
        EVAL: begin
          rsp_data  <= gate_eval(a_p0, b_p0, op_p0);
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            eval_count <= sat_inc(eval_count);
            if (rsp_data == 2'b10)
              x_count <= sat_inc(x_count);
            rr_ptr <= (idx_p0 == IDXW'(NREQ - 1)) ? '0 : idx_p0 + IDXW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed bench for gate_eval_arbiter: truth tables, round-robin order, backpressure,
// asynchronous reset mid-transaction and counter saturation (CNTW=4).
module tb_gate_eval_arbiter;

  localparam int NREQ = 4;
  localparam int CNTW = 4;

  localparam logic [1:0] OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11;
  localparam logic [1:0] V0 = 2'b00, V1 = 2'b01, VX = 2'b10, VXX = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_a, req_b, req_op;
  logic              rsp_valid;
  logic [NREQ-1:0]   rsp_id;
  logic [1:0]        rsp_data;
  logic              rsp_ready;
  logic              busy;
  logic [CNTW-1:0]   eval_count, x_count;

  int n_cmp = 0;
  int n_err = 0;

  gate_eval_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .eval_count(eval_count), .x_count(x_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single-requester transaction with rsp_ready held high; checks 2-cycle latency.
  task automatic txn(input int idx, input logic [1:0] op, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] exp, input string tag);
    int t;
    req_a[2*idx +: 2]  = a;
    req_b[2*idx +: 2]  = b;
    req_op[2*idx +: 2] = op;
    req_valid[idx]     = 1'b1;
    #1;
    t = 0;
    while (!req_ready[idx] && t < 20) begin
      step();
      t++;
    end
    chk({tag, "_rdy"}, 32'(req_ready[idx]), 32'd1);
    step();
    req_valid[idx] = 1'b0;
    step();
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk(tag, 32'(rsp_data), 32'(exp));
    chk({tag, "_id"}, 32'(rsp_id), 32'd1 << idx);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    // Reset values
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_eval_count", 32'(eval_count), 32'd0);
    chk("rst_x_count", 32'(x_count), 32'd0);
    do_reset();

    // Single requester, AND table
    txn(0, OP_AND, V0, VX, 2'b00, "and_0x");
    txn(0, OP_AND, VX, V0, 2'b00, "and_x0");
    txn(0, OP_AND, VX, V1, 2'b10, "and_x1");
    txn(0, OP_AND, V1, V1, 2'b01, "and_11");
    chk("single_eval_count", 32'(eval_count), 32'd4);
    chk("single_x_count", 32'(x_count), 32'd1);

    // All four valid continuously: order 0,1,2,3,0,1
    do_reset();
    req_op    = {OP_OR, OP_OR, OP_OR, OP_OR};
    req_a     = {V1, V1, V1, V1};
    req_b     = {V0, V0, V0, V0};
    req_valid = 4'hF;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", 32'(req_ready), 32'd1 << (i % 4));
      step();
      chk("rr_eval_ready", 32'(req_ready), 32'd0);
      chk("rr_busy", 32'(busy), 32'd1);
      chk("rr_early_vld", 32'(rsp_valid), 32'd0);
      step();
      chk("rr_vld", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'd1 << (i % 4));
      chk("rr_data", 32'(rsp_data), 32'd1);
      step();
    end
    req_valid = '0;
    chk("rr_eval_count", 32'(eval_count), 32'd6);

    // Backpressure on response, another requester waiting
    do_reset();
    rsp_ready = 1'b0;
    req_a[3:2] = V1;
    req_b[3:2] = VX;
    req_op[3:2] = OP_OR;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'b0010);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_count_held", 32'(eval_count), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_vld_clear", 32'(rsp_valid), 32'd0);
    chk("bp_count", 32'(eval_count), 32'd1);
    chk("bp_next_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    step();
    chk("bp_drop_idle", 32'(busy), 32'd0);

    // Op coverage on requester 2
    do_reset();
    txn(2, OP_XOR,  V1,  V1, 2'b00, "xor_11");
    txn(2, OP_XOR,  VX,  V0, 2'b10, "xor_x0");
    txn(2, OP_XOR,  V1,  V0, 2'b01, "xor_10");
    txn(2, OP_NAND, V0,  VX, 2'b01, "nand_0x");
    txn(2, OP_NAND, V1,  V1, 2'b00, "nand_11");
    txn(2, OP_AND,  VXX, V1, 2'b10, "and_enc11");
    txn(2, OP_OR,   V0,  VX, 2'b10, "or_0x");
    txn(2, OP_OR,   VXX, V1, 2'b01, "or_enc11_1");
    chk("ops_x_count", 32'(x_count), 32'd3);

    // Asynchronous reset during EVAL
    do_reset();
    txn(1, OP_AND, V1, V1, 2'b01, "pre_rst");
    req_op[7:6] = OP_AND;
    req_a[7:6]  = VX;
    req_b[7:6]  = VX;
    req_valid   = 4'b1000;
    #1;
    chk("mid_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(eval_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b1010;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'b0010);
    req_valid = 4'b1001;
    #1;
    chk("mid_ptr_zero_b", 32'(req_ready), 32'b0001);
    req_valid = '0;

    // Saturation at 2^CNTW-1 = 15
    do_reset();
    for (int i = 0; i < 17; i++)
      txn(0, OP_AND, VX, VXX, 2'b10, "sat_x");
    chk("sat_eval_count", 32'(eval_count), 32'd15);
    chk("sat_x_count", 32'(x_count), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_eval_arbiter.md
Name: gate_eval_arbiter

Overview:
- Shares one registered 4-state 2-input gate evaluator (AND/OR/XOR/NAND, X-aware truth tables) among NREQ requesters.
- Requesters submit operand pairs over valid/ready.
- A round-robin FSM grants one requester, evaluates the operands, and returns the result on a common response channel tagged by a one-hot requester ID.
- Sits between gate-level stimulus generators and the checker in the logic-gate test environment.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- CNTW, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- req_a  input  2*NREQ  operand A per requester, slice i = [2i+1:2i]. Encoding: 00=0, 01=1, 10=X, 11=X.
- req_b  input  2*NREQ  operand B per requester, same encoding.
- req_op  input  2*NREQ  op per requester: 00 AND, 01 OR, 10 XOR, 11 NAND.
- rsp_valid  output  1  response valid.
- rsp_id  output  NREQ  one-hot ID of the served requester.
- rsp_data  output  2  result: 00, 01, or 10 (X); 11 is never produced.
- rsp_ready  input  1  response consumer ready.
- busy  output  1  high whenever the FSM is not in IDLE.
- eval_count  output  CNTW  completed transactions, saturating.
- x_count  output  CNTW  completed transactions with result X, saturating.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=00, busy=0.
  - eval_count=0, x_count=0.
- Operand normalisation: 11 is treated as X everywhere.
- Truth tables:
  - AND: 0 if either operand is 0; 1 if both are 1; else X.
  - OR: 1 if either operand is 1; 0 if both are 0; else X.
  - XOR: X if either operand is X; else a^b.
  - NAND: AND result with 0 and 1 swapped; X stays X.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Grant = first set bit of req_valid, searching from rr_ptr upward with wrap-around.
  - req_ready is combinational and equals the grant one-hot (only in IDLE).
  - On handshake (any valid), capture that requester's a/b/op and ID, then go to EVAL.
  - No valid: stay in IDLE, req_ready=0.
- EVAL (exactly 1 cycle):
  - Compute and register rsp_data and rsp_id.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: clear rsp_valid, increment eval_count (and x_count if rsp_data=10), set rr_ptr=(served index+1) mod NREQ, return to IDLE.
- Counters saturate at 2^CNTW-1 and never wrap.
- req_ready is 0 in EVAL and RESP; at most one transaction is in flight.
- Minimum throughput: one transaction per 3 cycles. Request accept to rsp_valid = 2 cycles.
- Requester rules: a requester may drop req_valid without a handshake; it is then not served. Operands are sampled only on the handshake cycle.
- Simultaneous valids: only the round-robin winner is accepted; the others wait with ready=0.
- Reset asserted mid-transaction: the transaction is discarded immediately (asynchronous), all outputs return to reset values, and no response is issued after reset release.
- busy = (state != IDLE).

Test Plan:
- Single requester: req0 sends AND a=0, b=X; then a=X, b=0; then a=X, b=1; then a=1, b=1 -> rsp_data 00, 00, 10, 01 in order. rsp_id=0001 each time; eval_count=4, x_count=1.
- All four valid every cycle, rsp_ready=1 always -> grants served in order 0,1,2,3,0,1. One accept every 3 cycles; rsp_valid asserted 2 cycles after each accept.
- Backpressure: rsp_ready=0 for 5 cycles during RESP with OR a=1, b=X -> rsp_data=01 held stable; req_ready stays 0; one count only after release.
- Op coverage on req2 (XOR 1,1 -> 00; XOR X,0 -> 10; NAND 0,X -> 01; NAND 1,1 -> 00; operand encoding 11 treated as X: AND 11,1 -> 10) -> rsp_id=0100 for all.
- Reset mid-EVAL: assert rst_n=0 one cycle after accept -> rsp_valid=0 and counters=0 immediately; after release, no stale response, and the next grant starts from requester 0.
- Saturation with CNTW=4: 17 X-result transactions -> eval_count=15, x_count=15, no wrap.
